pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 118 +++++++++++
 tb/tb_pipe_stage_buf.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
//==============================================================================
// Module      : pipe_stage_buf
// Description : Valid/ready pipeline stage buffer with bubble (ctrl=0) insertion
//               and a saturating bubble counter. Define PIPE_STAGE_BUF_SKID_EN
//               for a registered-ready main+skid buffer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              r_main_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_xfer  = in_valid_i & in_ready_o;
    assign w_out_xfer = r_main_valid & out_ready_i;

`ifdef PIPE_STAGE_BUF_SKID_EN
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    // Ready comes straight from a flop, so out_ready_i never reaches upstream.
    assign in_ready_o = ~r_skid_valid;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
        end else if (flush_i) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_xfer) begin
            if (r_skid_valid) begin
                r_main_ctrl  <= r_skid_ctrl;
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_main_ctrl  <= in_ctrl_i;
                r_main_data  <= in_data_i;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            if (r_main_valid) begin
                r_skid_ctrl  <= in_ctrl_i;
                r_skid_data  <= in_data_i;
                r_skid_valid <= 1'b1;
            end else begin
                r_main_ctrl  <= in_ctrl_i;
                r_main_data  <= in_data_i;
                r_main_valid <= 1'b1;
            end
        end
    end
`else
    assign in_ready_o = ~r_main_valid | out_ready_i;

    // A simultaneous in/out transfer simply overwrites the head.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
        end else if (flush_i) begin
            r_main_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_main_ctrl  <= in_ctrl_i;
            r_main_data  <= in_data_i;
            r_main_valid <= 1'b1;
        end else if (w_out_xfer) begin
            r_main_valid <= 1'b0;
        end
    end
`endif

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (!r_main_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign out_valid_o  = r_main_valid;
    assign out_ctrl_o   = r_main_valid ? r_main_ctrl : '0;
    assign out_data_o   = r_main_data;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
//==============================================================================
// Module      : tb_pipe_stage_buf
// Description : Scoreboard bench for pipe_stage_buf (CNT_W=4), either build.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipe_stage_buf;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 11;
    localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_BUF_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              flush     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] in_ctrl   = '0;
    logic [DATA_W-1:0] in_data   = '0;
    logic              in_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  bubble_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [CTRL_W+DATA_W-1:0] exp_q[$];
    logic [CTRL_W+DATA_W-1:0] mon_e;
    logic              prev_stall = 1'b0;
    logic [CTRL_W-1:0] prev_ctrl  = '0;
    logic [DATA_W-1:0] prev_data  = '0;
    bit                done       = 1'b0;

    pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_ctrl_i   (in_ctrl),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_ctrl_o  (out_ctrl),
        .out_data_o  (out_data),
        .bubble_cnt_o(bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required run to finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one beat until accepted; the expected beat is queued at acceptance.
    task automatic send(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({c, d});
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        idle(1);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops on every output transfer, checks bubbles and stall stability.
    always @(negedge clk) begin
        if (!out_valid)
            chk("bubble_ctrl_zero", 64'(out_ctrl), 64'd0);
        if (prev_stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_ctrl", 64'(out_ctrl), 64'(prev_ctrl));
            chk("stall_data", out_data, prev_data);
        end
        if (rst_n && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got ctrl %h data %h, required no beat", out_ctrl, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_ctrl", 64'(out_ctrl), 64'(mon_e[CTRL_W+DATA_W-1:DATA_W]));
                chk("beat_data", out_data, mon_e[DATA_W-1:0]);
            end
        end
        prev_stall = rst_n && !flush && out_valid && !out_ready;
        prev_ctrl  = out_ctrl;
        prev_data  = out_data;
    end

    initial begin
        // Reset state
        idle(2);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_bubble", 64'(bubble_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Single beat with ready high: valid one cycle later, then a bubble
        out_ready = 1'b1;
        send(11'h5A5, 64'h1234);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_ctrl", 64'(out_ctrl), 64'h5A5);
        idle(1);
        chk("single_after_valid", 64'(out_valid), 64'd0);
        chk("single_after_ctrl", 64'(out_ctrl), 64'd0);
        chk("single_data_hold", out_data, 64'h1234);

        // Beats 1..8 with out_ready toggling 1,0,1,0
        done = 1'b0;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send(CTRL_W'(i), 64'hA000_0000_0000_0000 | 64'(i));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    if (!done) out_ready = ~out_ready;
                end
            end
        join
        drain();

        // Fill to capacity with out_ready low, then release
        out_ready = 1'b0;
        for (int i = 1; i <= CAP; i++)
            send(CTRL_W'(16 + i), 64'hB0 + 64'(i));
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_ctrl  = CTRL_W'(16 + CAP + 1);
        in_data  = 64'hB0 + 64'(CAP + 1);
        idle(3);
        chk("full_in_ready_held", 64'(in_ready), 64'd0);
        chk("full_head_data", out_data, 64'hB1);
        out_ready = 1'b1;
        send(CTRL_W'(16 + CAP + 1), 64'hB0 + 64'(CAP + 1));
        drain();

        // Flush with held beats and a presented beat
        out_ready = 1'b0;
        for (int i = 1; i <= CAP; i++)
            send(CTRL_W'(32 + i), 64'hC0 + 64'(i));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 11'h7FF;
        in_data  = 64'hFFFF;
        idle(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ctrl", 64'(out_ctrl), 64'd0);
        chk("flush_data_kept", out_data, 64'hC1);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        idle(5);

        // Bubble counter: counts idle cycles, survives flush, saturates at 15
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("bubble_after_rst", 64'(bubble_cnt), 64'd0);
        idle(3);
        chk("bubble_3", 64'(bubble_cnt), 64'd3);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        chk("bubble_flush_kept", 64'(bubble_cnt), 64'd4);
        idle(16);
        chk("bubble_saturated", 64'(bubble_cnt), 64'd15);

        // Reset together with flush and a presented beat while a beat is held
        out_ready = 1'b0;
        send(11'h3C3, 64'hDEAD_BEEF_CAFE_F00D);
        chk("held_valid", 64'(out_valid), 64'd1);
        rst_n    = 1'b0;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 11'h155;
        in_data  = 64'h5555;
        idle(1);
        exp_q.delete();
        chk("rstflush_valid", 64'(out_valid), 64'd0);
        chk("rstflush_ctrl", 64'(out_ctrl), 64'd0);
        chk("rstflush_data", out_data, 64'd0);
        chk("rstflush_bubble", 64'(bubble_cnt), 64'd0);
        chk("rstflush_in_ready", 64'(in_ready), 64'd1);
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("post_rst_no_beat", 64'(out_valid), 64'd0);
        chk("post_rst_bubble", 64'(bubble_cnt), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
